tx_axis_arbiter: RTL and testbench
==================================

TX_AXIS_ARBITER -- requirements
Module: tx_axis_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 2, meaning the number of AXIS requesters sharing one MAC transmit input (legal range 2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the AXIS data width in bits; KEEP_WIDTH = DATA_WIDTH/8.
REQ-003 The block SHALL have port tx_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port tx_rst, input, 1 bit, a synchronous, active-high reset.
REQ-005 The block SHALL have port in_slave_tx_tdata, input, NUM_PORTS*DATA_WIDTH bits; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-006 The block SHALL have port in_slave_tx_tkeep, input, NUM_PORTS*KEEP_WIDTH bits, per-port byte enables, packed the same way.
REQ-007 The block SHALL have ports in_slave_tx_tvalid and in_slave_tx_tlast, each input, NUM_PORTS bits, one bit per port.
REQ-008 The block SHALL have port out_slave_tx_tready, output, NUM_PORTS bits, per-port ready.
REQ-009 The block SHALL have ports out_master_tx_tdata (DATA_WIDTH), out_master_tx_tkeep (KEEP_WIDTH), out_master_tx_tvalid (1) and out_master_tx_tlast (1), all outputs, forming the stream to the MAC.
REQ-010 The block SHALL have port in_master_tx_tready, input, 1 bit, the MAC ready.
REQ-011 The block SHALL have port in_port_enable, input, NUM_PORTS bits; a port whose bit is 0 is never newly granted.
REQ-012 The block SHALL have port out_grant, output, NUM_PORTS bits, a one-hot registered grant, all-zero when no port is granted.
REQ-013 The block SHALL have port out_busy, output, 1 bit, high while in state XFER.
REQ-014 The block SHALL have port out_frame_done, output, 1 bit, a one-cycle pulse after each completed frame.
REQ-015 The block SHALL have port out_frame_count, output, 16 bits, the count of frames forwarded.

Function
REQ-016 The FSM SHALL have two states: ARB (no grant) and XFER (one port locked).
REQ-017 In ARB, when the eligible set (tvalid & in_port_enable) is non-empty, the FSM SHALL select one port by round-robin, register its one-hot grant, and enter XFER on the next edge.
REQ-018 Round-robin search SHALL start at port (last_grant+1) mod NUM_PORTS and wrap; last_grant resets to NUM_PORTS-1, so port 0 has first priority after reset.
REQ-019 In ARB, all out_slave_tx_tready bits and out_master_tx_tvalid SHALL be 0; no beat transfers.
REQ-020 In XFER, the master data, keep, valid and last outputs SHALL combinationally mirror the granted port.
REQ-021 In XFER, out_slave_tx_tready[g] SHALL equal in_master_tx_tready for the granted port g, and every other ready bit SHALL be 0.
REQ-022 A beat transfers only when tvalid[g] and in_master_tx_tready are both 1; each transferred beat increments an internal 12-bit beat counter.
REQ-023 The grant SHALL be held until a beat with tlast[g]=1 transfers, with no preemption, even if in_port_enable[g] falls mid-frame.
REQ-024 On the tlast beat, the FSM SHALL perform all of the following on the next edge:
- return to ARB;
- set last_grant=g;
- clear out_grant;
- pulse out_frame_done for one cycle;
- increment out_frame_count (wraps 0xFFFF->0);
- clear the beat counter.
REQ-025 Frame-to-frame turnaround SHALL be exactly one ARB cycle; the sustained throughput is one beat per cycle within a frame.
REQ-026 tvalid dropping mid-frame SHALL simply stall the transfer; the grant is kept.
REQ-027 If the beat counter reaches 4095 without tlast, the block SHALL continue forwarding with the counter saturated; no abort is performed.
REQ-028 Requests arriving in the same cycle SHALL be resolved by round-robin order only; tkeep is not inspected.

Reset
REQ-029 While tx_rst=1 at a clock edge, the next state SHALL be ARB with out_grant=0, out_busy=0, out_frame_done=0, out_frame_count=0, beat counter=0 and last_grant=NUM_PORTS-1.
REQ-030 While tx_rst=1, out_slave_tx_tready SHALL be 0 and out_master_tx_tvalid SHALL be 0.
REQ-031 A reset asserted mid-frame SHALL abandon the frame with no tlast emitted; the downstream MAC is reset by the same tx_rst.

Verification
REQ-032 Single port: port0 sends a 4-beat frame with tready=1 -> grant=01 one cycle after tvalid; 4 master beats with tlast on the 4th; frame_done pulses; frame_count=1.
REQ-033 Contention: both ports hold valid frames (3 beats each) continuously -> order is p0, p1, p0, p1; exactly 1 idle cycle between frames; frame_count=4 after four frames.
REQ-034 Backpressure: in_master_tx_tready toggles 1,0,1,0 during a 4-beat frame -> 4 beats transfer over 7 cycles; slave ready mirrors master ready; data order is preserved.
REQ-035 Enable: in_port_enable=2'b10 with both ports valid -> only p1 is granted; clearing enable[1] mid-frame still completes p1's frame.
REQ-036 Reset mid-frame: assert tx_rst after beat 2 of 5 -> the next cycle shows grant=0, tvalid_out=0 and count=0; after release, port0 is granted first.
REQ-037 Stall: port1 tvalid is low for 10 cycles mid-frame while port0 is valid -> the grant stays on p1 and port0 is served only after p1's tlast.

Source files
------------

// File: rtl/tx_axis_arbiter.sv
// Round-robin arbiter that funnels NUM_PORTS AXI-Stream transmit
// requesters into a single MAC transmit stream, one whole frame at a time.
//
// Ports:
//   tx_clk, tx_rst         clock and synchronous active-high reset
//   in_slave_tx_*          packed per-port AXIS inputs (data/keep/valid/last)
//   out_slave_tx_tready    per-port ready back to the requesters
//   out_master_tx_*        AXIS stream towards the MAC
//   in_master_tx_tready    MAC ready
//   in_port_enable         per-port permission to be newly granted
//   out_grant              registered one-hot grant (zero while arbitrating)
//   out_busy               high while a frame is locked to a port
//   out_frame_done         one-cycle pulse after each completed frame
//   out_frame_count        wrapping count of forwarded frames

module tx_axis_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                            tx_clk,
    input  logic                            tx_rst,

    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_slave_tx_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0] in_slave_tx_tkeep,
    input  logic [NUM_PORTS-1:0]            in_slave_tx_tvalid,
    input  logic [NUM_PORTS-1:0]            in_slave_tx_tlast,
    output logic [NUM_PORTS-1:0]            out_slave_tx_tready,

    output logic [DATA_WIDTH-1:0]           out_master_tx_tdata,
    output logic [KEEP_WIDTH-1:0]           out_master_tx_tkeep,
    output logic                            out_master_tx_tvalid,
    output logic                            out_master_tx_tlast,
    input  logic                            in_master_tx_tready,

    input  logic [NUM_PORTS-1:0]            in_port_enable,
    output logic [NUM_PORTS-1:0]            out_grant,
    output logic                            out_busy,
    output logic                            out_frame_done,
    output logic [15:0]                     out_frame_count
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } state_e;

    state_e               state_q;
    logic [NUM_PORTS-1:0] grant_q;
    logic [IDX_W-1:0]     gidx_q;
    logic [IDX_W-1:0]     last_q;
    logic                 done_q;
    logic [15:0]          count_q;
    logic [11:0]          beats_q;

    logic [NUM_PORTS-1:0] elig;
    logic [IDX_W-1:0]     pick_d;
    logic                 hit_d;
    logic [IDX_W-1:0]     cand;
    int                   idx;

    logic                 xfer_act;
    logic                 valid_g;
    logic                 last_g;
    logic                 beat;

    // Round-robin search. Candidates are visited from the farthest
    // (last_grant itself) to the nearest (last_grant+1), so the nearest
    // eligible port is the one left in pick_d.
    always_comb begin
        elig   = in_slave_tx_tvalid & in_port_enable;
        pick_d = '0;
        hit_d  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx  = (int'(last_q) + i) % NUM_PORTS;
            cand = IDX_W'(idx);
            if (elig[cand]) begin
                pick_d = cand;
                hit_d  = 1'b1;
            end
        end
    end

    // The locked port is muxed straight through; reset forces the
    // handshake signals low so nothing moves while tx_rst is high.
    assign xfer_act = (state_q == XFER) && !tx_rst;
    assign valid_g  = in_slave_tx_tvalid[gidx_q];
    assign last_g   = in_slave_tx_tlast[gidx_q];
    assign beat     = xfer_act && valid_g && in_master_tx_tready;

    assign out_master_tx_tdata =
        in_slave_tx_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    assign out_master_tx_tkeep =
        in_slave_tx_tkeep[gidx_q*KEEP_WIDTH +: KEEP_WIDTH];
    assign out_master_tx_tvalid = xfer_act && valid_g;
    assign out_master_tx_tlast  = xfer_act && last_g;

    assign out_slave_tx_tready =
        xfer_act ? (grant_q & {NUM_PORTS{in_master_tx_tready}})
                 : '0;

    assign out_grant       = grant_q;
    assign out_busy        = (state_q == XFER);
    assign out_frame_done  = done_q;
    assign out_frame_count = count_q;

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_q <= ARB;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_PORTS - 1);
            done_q  <= 1'b0;
            count_q <= '0;
            beats_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ARB: begin
                    if (hit_d) begin
                        state_q <= XFER;
                        grant_q <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_d;
                        gidx_q  <= pick_d;
                    end
                end
                XFER: begin
                    // No preemption: only the tlast beat releases the lock.
                    if (beat) begin
                        if (last_g) begin
                            state_q <= ARB;
                            grant_q <= '0;
                            last_q  <= gidx_q;
                            done_q  <= 1'b1;
                            count_q <= count_q + 16'd1;
                            beats_q <= '0;
                        end else if (beats_q != 12'hFFF) begin
                            // Oversized frames keep flowing; the counter
                            // simply saturates.
                            beats_q <= beats_q + 12'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ARB;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Directed, table-driven bench for tx_axis_arbiter with two 32-bit ports.
// Each table row is one clock cycle of inputs plus the expected outputs.

module tb_tx_axis_arbiter;

    localparam int NP = 2;
    localparam int DW = 32;
    localparam int KW = DW / 8;

    logic              clk;
    logic              rst;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*KW-1:0]  s_tkeep;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [NP-1:0]     en;
    logic [NP-1:0]     grant;
    logic              busy;
    logic              fdone;
    logic [15:0]       fcount;

    int n_checks;
    int n_fail;

    tx_axis_arbiter #(
        .NUM_PORTS (NP),
        .DATA_WIDTH(DW)
    ) dut (
        .tx_clk              (clk),
        .tx_rst              (rst),
        .in_slave_tx_tdata   (s_tdata),
        .in_slave_tx_tkeep   (s_tkeep),
        .in_slave_tx_tvalid  (s_tvalid),
        .in_slave_tx_tlast   (s_tlast),
        .out_slave_tx_tready (s_tready),
        .out_master_tx_tdata (m_tdata),
        .out_master_tx_tkeep (m_tkeep),
        .out_master_tx_tvalid(m_tvalid),
        .out_master_tx_tlast (m_tlast),
        .in_master_tx_tready (m_tready),
        .in_port_enable      (en),
        .out_grant           (grant),
        .out_busy            (busy),
        .out_frame_done      (fdone),
        .out_frame_count     (fcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [1:0]  l;
        logic [1:0]  en;
        logic        mr;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  eg;
        logic        ev;
        logic        el;
        logic [31:0] ed;
        logic [1:0]  es;
        logic        edone;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst_, input logic [1:0] v,
                       input logic [1:0] l, input logic [1:0] en_,
                       input logic mr, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [1:0] eg,
                       input logic ev, input logic el,
                       input logic [31:0] ed, input logic [1:0] es,
                       input logic edone, input logic [15:0] ecnt);
        vec_t r;
        r.rst = rst_; r.v = v; r.l = l; r.en = en_; r.mr = mr;
        r.d0 = d0; r.d1 = d1; r.eg = eg; r.ev = ev; r.el = el;
        r.ed = ed; r.es = es; r.edone = edone; r.ecnt = ecnt;
        tbl.push_back(r);
    endtask

    task automatic idle_inputs();
        s_tdata  = '0;
        s_tkeep  = {4'h3, 4'hF};
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        en       = 2'b11;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst      = tbl[i].rst;
            s_tvalid = tbl[i].v;
            s_tlast  = tbl[i].l;
            en       = tbl[i].en;
            m_tready = tbl[i].mr;
            s_tdata  = {tbl[i].d1, tbl[i].d0};
            #1;
            check($sformatf("%s[%0d].grant", tag, i), 32'(grant), 32'(tbl[i].eg));
            check($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(tbl[i].eg != 2'b00));
            check($sformatf("%s[%0d].mvalid", tag, i), 32'(m_tvalid), 32'(tbl[i].ev));
            check($sformatf("%s[%0d].sready", tag, i), 32'(s_tready), 32'(tbl[i].es));
            check($sformatf("%s[%0d].done", tag, i), 32'(fdone), 32'(tbl[i].edone));
            check($sformatf("%s[%0d].count", tag, i), 32'(fcount), 32'(tbl[i].ecnt));
            if (tbl[i].ev) begin
                check($sformatf("%s[%0d].mdata", tag, i), m_tdata, tbl[i].ed);
                check($sformatf("%s[%0d].mlast", tag, i), 32'(m_tlast), 32'(tbl[i].el));
                check($sformatf("%s[%0d].mkeep", tag, i), 32'(m_tkeep),
                      tbl[i].eg[0] ? 32'hF : 32'h3);
            end
        end
        tbl.delete();
    endtask

    function automatic logic [31:0] dat(int p, int fr, int b);
        return 32'h1000 * (p + 1) + fr * 16 + b;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();

        // Reset state
        do_reset();
        @(negedge clk);
        #1;
        check("rst.grant", 32'(grant), 32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.done", 32'(fdone), 32'h0);
        check("rst.count", 32'(fcount), 32'h0);
        check("rst.mvalid", 32'(m_tvalid), 32'h0);
        check("rst.sready", 32'(s_tready), 32'h0);

        // Single port, 4-beat frame
        add(0, 2'b01, 2'b00, 2'b11, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        for (int b = 0; b < 4; b++)
            add(0, 2'b01, (b == 3) ? 2'b01 : 2'b00, 2'b11, 1,
                32'hA000_0000 + b, 0,
                2'b01, 1, b == 3, 32'hA000_0000 + b, 2'b01, 0, 0);
        add(0, 2'b00, 2'b00, 2'b11, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1);
        add(0, 2'b00, 2'b00, 2'b11, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1);
        run_table("single");

        // Contention: p0, p1, p0, p1 with one idle cycle between frames
        do_reset();
        for (int f = 0; f <= 4; f++) begin
            int n0, n1, p;
            logic [1:0] g;
            n0 = (f + 1) / 2;
            n1 = f / 2;
            p  = f % 2;
            g  = (p == 0) ? 2'b01 : 2'b10;
            add(0, (f == 4) ? 2'b00 : 2'b11, 2'b00, 2'b11, 1,
                dat(0, n0, 0), dat(1, n1, 0),
                2'b00, 0, 0, 0, 2'b00, f > 0, 16'(f));
            if (f < 4) begin
                for (int b = 0; b < 3; b++)
                    add(0, 2'b11, (b == 2) ? g : 2'b00, 2'b11, 1,
                        dat(0, n0, (p == 0) ? b : 0),
                        dat(1, n1, (p == 1) ? b : 0),
                        g, 1, b == 2, dat(p, (p == 1) ? n1 : n0, b),
                        g, 0, 16'(f));
            end
        end
        run_table("contend");

        // Backpressure: MAC ready toggles, 4 beats over 7 cycles
        do_reset();
        add(0, 2'b01, 2'b00, 2'b11, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        begin
            int b;
            logic mr;
            b = 0;
            for (int k = 0; k < 7; k++) begin
                mr = (k % 2 == 0);
                add(0, 2'b01, (b == 3) ? 2'b01 : 2'b00, 2'b11, mr,
                    32'hB000_0000 + b, 0,
                    2'b01, 1, b == 3, 32'hB000_0000 + b,
                    mr ? 2'b01 : 2'b00, 0, 0);
                if (mr) b++;
            end
        end
        add(0, 2'b00, 2'b00, 2'b11, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1);
        run_table("bp");

        // Enable mask: only p1 may be granted; drop enable mid-frame
        do_reset();
        add(0, 2'b11, 2'b00, 2'b10, 1, 32'hC0, 32'hD0,
            2'b00, 0, 0, 0, 2'b00, 0, 0);
        add(0, 2'b11, 2'b00, 2'b10, 1, 32'hC0, 32'hD0,
            2'b10, 1, 0, 32'hD0, 2'b10, 0, 0);
        add(0, 2'b11, 2'b00, 2'b00, 1, 32'hC0, 32'hD1,
            2'b10, 1, 0, 32'hD1, 2'b10, 0, 0);
        add(0, 2'b11, 2'b10, 2'b00, 1, 32'hC0, 32'hD2,
            2'b10, 1, 1, 32'hD2, 2'b10, 0, 0);
        add(0, 2'b11, 2'b00, 2'b00, 1, 32'hC0, 32'hD0,
            2'b00, 0, 0, 0, 2'b00, 1, 1);
        add(0, 2'b11, 2'b00, 2'b00, 1, 32'hC0, 32'hD0,
            2'b00, 0, 0, 0, 2'b00, 0, 1);
        run_table("enable");

        // Stall: p1 holds the grant through 10 invalid cycles
        do_reset();
        add(0, 2'b10, 2'b00, 2'b11, 1, 32'hE0, 32'hF0,
            2'b00, 0, 0, 0, 2'b00, 0, 0);
        add(0, 2'b10, 2'b00, 2'b11, 1, 32'hE0, 32'hF0,
            2'b10, 1, 0, 32'hF0, 2'b10, 0, 0);
        for (int k = 0; k < 10; k++)
            add(0, 2'b01, 2'b00, 2'b11, 1, 32'hE0, 32'hF1,
                2'b10, 0, 0, 0, 2'b10, 0, 0);
        add(0, 2'b11, 2'b10, 2'b11, 1, 32'hE0, 32'hF1,
            2'b10, 1, 1, 32'hF1, 2'b10, 0, 0);
        add(0, 2'b01, 2'b00, 2'b11, 1, 32'hE0, 0,
            2'b00, 0, 0, 0, 2'b00, 1, 1);
        add(0, 2'b01, 2'b00, 2'b11, 1, 32'hE0, 0,
            2'b01, 1, 0, 32'hE0, 2'b01, 0, 1);
        run_table("stall");

        // Reset mid-frame: p1 frame abandoned, p0 wins first afterwards
        do_reset();
        add(0, 2'b01, 2'b00, 2'b11, 1, 32'h50, 0,
            2'b00, 0, 0, 0, 2'b00, 0, 0);
        add(0, 2'b01, 2'b01, 2'b11, 1, 32'h50, 0,
            2'b01, 1, 1, 32'h50, 2'b01, 0, 0);
        add(0, 2'b10, 2'b00, 2'b11, 1, 0, 32'h60,
            2'b00, 0, 0, 0, 2'b00, 1, 1);
        add(0, 2'b10, 2'b00, 2'b11, 1, 0, 32'h60,
            2'b10, 1, 0, 32'h60, 2'b10, 0, 1);
        add(0, 2'b10, 2'b00, 2'b11, 1, 0, 32'h61,
            2'b10, 1, 0, 32'h61, 2'b10, 0, 1);
        add(1, 2'b11, 2'b00, 2'b11, 1, 32'h50, 32'h62,
            2'b10, 0, 0, 0, 2'b00, 0, 1);
        add(0, 2'b11, 2'b00, 2'b11, 1, 32'h50, 32'h62,
            2'b00, 0, 0, 0, 2'b00, 0, 0);
        add(0, 2'b11, 2'b00, 2'b11, 1, 32'h50, 32'h62,
            2'b01, 1, 0, 32'h50, 2'b01, 0, 0);
        run_table("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
